// File: rtl/cal_angle_arbiter.sv
// Round-robin arbiter sharing one LAT-cycle angle datapath between NUM_CH channels,
// with a latency-matched channel tag pipe. Define CAL_ANGLE_ARB_STATS_EN for per-channel grant counters.
module cal_angle_arbiter #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH),
  parameter int LAT    = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en_i,
  input  logic                 flush_i,
  input  logic [NUM_CH-1:0]    req_val_i,
  output logic [NUM_CH-1:0]    req_rdy_o,
  input  logic [8*NUM_CH-1:0]  req_real_i,
  input  logic [8*NUM_CH-1:0]  req_imag_i,
  output logic                 dp_val_o,
  output logic [7:0]           dp_real_o,
  output logic [7:0]           dp_imag_o,
  input  logic                 dp_val_i,
  input  logic [15:0]          dp_angle_i,
  output logic [NUM_CH-1:0]    res_val_o,
  output logic [15:0]          res_angle_o,
  output logic [CH_W-1:0]      res_ch_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o
`ifdef CAL_ANGLE_ARB_STATS_EN
  ,
  output logic [16*NUM_CH-1:0] grant_cnt_o
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam logic [CH_W:0]     NUM_CH_W = (CH_W+1)'(NUM_CH);
  localparam logic [NUM_CH-1:0] ONE_CH   = {{(NUM_CH-1){1'b0}}, 1'b1};

  state_e                state_r;
  state_e                state_nxt_s;
  logic                  done_s;
  logic [CH_W-1:0]       rr_ptr_r;
  logic [2*NUM_CH-1:0]   req_rot_s;
  logic                  gnt_vld_s;
  logic [CH_W:0]         gnt_off_s;
  logic [CH_W:0]         gnt_sum_s;
  logic [CH_W-1:0]       gnt_ch_s;
  logic [CH_W:0]         ptr_sum_s;
  logic [CH_W-1:0]       ptr_nxt_s;
  logic [8*NUM_CH-1:0]   real_sh_s;
  logic [8*NUM_CH-1:0]   imag_sh_s;
  logic [LAT:0]          tag_vld_r;
  logic [CH_W-1:0]       tag_ch_r [LAT+1];

  // Next-state logic; the drain is complete once nothing is issued or in flight
  always_comb begin
    state_nxt_s = state_r;
    done_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (en_i) state_nxt_s = ST_RUN;
        else      state_nxt_s = ST_IDLE;
      end
      ST_RUN: begin
        if (flush_i || !en_i) state_nxt_s = ST_DRAIN;
        else                  state_nxt_s = ST_RUN;
      end
      ST_DRAIN: begin
        if (!dp_val_o && (tag_vld_r == '0)) begin
          state_nxt_s = ST_IDLE;
          done_s      = 1'b1;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  assign done_o = done_s;
  assign busy_o = (state_r != ST_IDLE);

  // Round-robin search over the request vector rotated so rr_ptr sits at bit 0
  always_comb begin
    req_rot_s = {req_val_i, req_val_i} >> rr_ptr_r;
    gnt_vld_s = 1'b0;
    gnt_off_s = '0;
    if (state_r == ST_RUN) begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (req_rot_s[i]) begin
          gnt_vld_s = 1'b1;
          gnt_off_s = (CH_W+1)'(i);
        end else begin
          gnt_off_s = gnt_off_s;
        end
      end
    end else begin
      gnt_vld_s = 1'b0;
    end
    gnt_sum_s = {1'b0, rr_ptr_r} + gnt_off_s;
    gnt_ch_s  = (gnt_sum_s >= NUM_CH_W) ? CH_W'(gnt_sum_s - NUM_CH_W) : gnt_sum_s[CH_W-1:0];
    ptr_sum_s = {1'b0, gnt_ch_s} + {{CH_W{1'b0}}, 1'b1};
    ptr_nxt_s = (ptr_sum_s >= NUM_CH_W) ? {CH_W{1'b0}} : ptr_sum_s[CH_W-1:0];
    req_rdy_o = gnt_vld_s ? (ONE_CH << gnt_ch_s) : {NUM_CH{1'b0}};
    real_sh_s = req_real_i >> {gnt_ch_s, 3'b000};
    imag_sh_s = req_imag_i >> {gnt_ch_s, 3'b000};
  end

  // State, round-robin pointer and datapath issue registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      rr_ptr_r  <= '0;
      dp_val_o  <= 1'b0;
      dp_real_o <= 8'h00;
      dp_imag_o <= 8'h00;
    end else begin
      state_r  <= state_nxt_s;
      dp_val_o <= gnt_vld_s;
      if (gnt_vld_s) begin
        rr_ptr_r  <= ptr_nxt_s;
        dp_real_o <= real_sh_s[7:0];
        dp_imag_o <= imag_sh_s[7:0];
      end
    end
  end

  // Channel tag pipe: stage 0 rides with dp_val_o, stage LAT lines up with dp_val_i
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld_r <= '0;
      for (int i = 0; i <= LAT; i++) tag_ch_r[i] <= '0;
    end else begin
      tag_vld_r   <= {tag_vld_r[LAT-1:0], gnt_vld_s};
      tag_ch_r[0] <= gnt_ch_s;
      for (int i = 1; i <= LAT; i++) tag_ch_r[i] <= tag_ch_r[i-1];
    end
  end

  // Result return; a valid/tag disagreement drops the result and latches err_o
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_val_o   <= '0;
      res_angle_o <= 16'h0000;
      res_ch_o    <= '0;
      err_o       <= 1'b0;
    end else begin
      if (dp_val_i && tag_vld_r[LAT]) begin
        res_val_o   <= ONE_CH << tag_ch_r[LAT];
        res_angle_o <= dp_angle_i;
        res_ch_o    <= tag_ch_r[LAT];
      end else begin
        res_val_o   <= '0;
      end
      if (dp_val_i != tag_vld_r[LAT]) err_o <= 1'b1;
    end
  end

`ifdef CAL_ANGLE_ARB_STATS_EN
  logic [15:0] gcnt_r [NUM_CH];

  // Saturating per-channel grant counters, restarted on every entry to RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) gcnt_r[c] <= 16'h0000;
    end else if ((state_r == ST_IDLE) && (state_nxt_s == ST_RUN)) begin
      for (int c = 0; c < NUM_CH; c++) gcnt_r[c] <= 16'h0000;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (gnt_vld_s && (gnt_ch_s == CH_W'(c)) && (gcnt_r[c] != 16'hFFFF))
          gcnt_r[c] <= gcnt_r[c] + 16'h0001;
      end
    end
  end

  // Pack the counters onto the output bus
  always_comb begin
    grant_cnt_o = '0;
    for (int c = 0; c < NUM_CH; c++) grant_cnt_o[16*c +: 16] = gcnt_r[c];
  end
`endif

endmodule
